// File: rtl/clock_control.sv
// Run/step/reset controller: derives core clock enable and active-low reset from debounced buttons and HALT.
// Latency: button press acts DEBOUNCE_CYCLES+3 edges after the raw level rises; HALT acts on the edge it is sampled.
// Backpressure: none; HALT and button presses are the only flow control, arbitrated RESET > HALT > STOP > STEP > RUN.
module clock_control #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RESET_CYCLES    = 4,
    parameter int AUTORUN         = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RUN_BTN,
    input  logic        STOP_BTN,
    input  logic        STEP_BTN,
    input  logic        RESET_BTN,
    input  logic        HALT,
    output logic        CPU_RST_bar,
    output logic        CPU_CLK_EN,
    output logic [2:0]  STATE,
    output logic [15:0] CYCLE_COUNT
);

    localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int RC_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_STOPPED = 3'd1,
        S_RUNNING = 3'd2,
        S_STEP    = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            rst_load;
    logic [RC_W-1:0] rst_cnt;
    logic [3:0]      raw_btn;
    logic [3:0]      press;

    assign raw_btn = {RESET_BTN, STEP_BTN, STOP_BTN, RUN_BTN};

    // One synchroniser + debouncer per button; press fires once on the accepted rising edge.
    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic            sync1;
        logic            sync2;
        logic            level;
        logic            level_d;
        logic [DB_W-1:0] db_cnt;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                sync1   <= 1'b0;
                sync2   <= 1'b0;
                level   <= 1'b0;
                level_d <= 1'b0;
                db_cnt  <= '0;
            end else begin
                sync1   <= raw_btn[i];
                sync2   <= sync1;
                level_d <= level;
                if (sync2 == level) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level  <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

        assign press[i] = level & ~level_d;
    end

    logic run_press, stop_press, step_press, reset_press;
    assign run_press   = press[0];
    assign stop_press  = press[1];
    assign step_press  = press[2];
    assign reset_press = press[3];

    always_comb begin
        next_state = state;
        rst_load   = 1'b0;
        if (reset_press) begin
            next_state = S_RESET;
            rst_load   = 1'b1;
        end else begin
            case (state)
                S_RESET: begin
                    if (rst_cnt == RC_W'(1))
                        next_state = (AUTORUN != 0) ? S_RUNNING : S_STOPPED;
                end
                S_STOPPED: begin
                    if (HALT)
                        next_state = S_HALTED;
                    else if (stop_press)
                        next_state = S_STOPPED;
                    else if (step_press)
                        next_state = S_STEP;
                    else if (run_press)
                        next_state = S_RUNNING;
                end
                S_RUNNING: begin
                    if (HALT)
                        next_state = S_HALTED;
                    else if (stop_press)
                        next_state = S_STOPPED;
                end
                S_STEP:    next_state = HALT ? S_HALTED : S_STOPPED;
                S_HALTED:  next_state = S_HALTED;
                default:   next_state = S_RESET;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_RESET;
            rst_cnt <= RC_W'(RESET_CYCLES);
        end else begin
            state <= next_state;
            if (rst_load)
                rst_cnt <= RC_W'(RESET_CYCLES);
            else if (state == S_RESET && rst_cnt != RC_W'(1))
                rst_cnt <= rst_cnt - RC_W'(1);
        end
    end

    // Outputs are registered from next_state so the enable drops on the same edge HALT/STOP is taken.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CPU_RST_bar <= 1'b0;
            CPU_CLK_EN  <= 1'b1;
            CYCLE_COUNT <= '0;
        end else begin
            CPU_RST_bar <= (next_state != S_RESET);
            CPU_CLK_EN  <= (next_state == S_RESET) || (next_state == S_RUNNING) ||
                           (next_state == S_STEP);
            if (next_state == S_RESET)
                CYCLE_COUNT <= '0;
            else if (CPU_CLK_EN && CPU_RST_bar)
                CYCLE_COUNT <= CYCLE_COUNT + 16'd1;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_clock_control.sv
// Directed bench for clock_control: instance a (AUTORUN=0) and instance b (AUTORUN=1), both with 4-cycle debounce/reset.
module tb_clock_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [3:0]  btn_a, btn_b;   // {reset, step, stop, run}
    logic        halt_a, halt_b;
    logic        rst_bar_a, rst_bar_b, en_a, en_b;
    logic [2:0]  state_a, state_b;
    logic [15:0] cnt_a, cnt_b;

    int checks   = 0;
    int failures = 0;

    clock_control #(.DEBOUNCE_CYCLES(4), .RESET_CYCLES(4), .AUTORUN(0)) dut_a (
        .CLK(clk), .RST(rst_a),
        .RUN_BTN(btn_a[0]), .STOP_BTN(btn_a[1]), .STEP_BTN(btn_a[2]), .RESET_BTN(btn_a[3]),
        .HALT(halt_a), .CPU_RST_bar(rst_bar_a), .CPU_CLK_EN(en_a),
        .STATE(state_a), .CYCLE_COUNT(cnt_a)
    );

    clock_control #(.DEBOUNCE_CYCLES(4), .RESET_CYCLES(4), .AUTORUN(1)) dut_b (
        .CLK(clk), .RST(rst_b),
        .RUN_BTN(btn_b[0]), .STOP_BTN(btn_b[1]), .STEP_BTN(btn_b[2]), .RESET_BTN(btn_b[3]),
        .HALT(halt_b), .CPU_RST_bar(rst_bar_b), .CPU_CLK_EN(en_b),
        .STATE(state_b), .CYCLE_COUNT(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] st, input logic en,
                         input logic rb, input logic [15:0] cnt);
        chk({tag, ".state"}, 32'(state_a), 32'(st));
        chk({tag, ".en"},    32'(en_a),    32'(en));
        chk({tag, ".rstb"},  32'(rst_bar_a), 32'(rb));
        chk({tag, ".cnt"},   32'(cnt_a),   32'(cnt));
    endtask

    task automatic chk_b(input string tag, input logic [2:0] st, input logic en,
                         input logic rb, input logic [15:0] cnt);
        chk({tag, ".state"}, 32'(state_b), 32'(st));
        chk({tag, ".en"},    32'(en_b),    32'(en));
        chk({tag, ".rstb"},  32'(rst_bar_b), 32'(rb));
        chk({tag, ".cnt"},   32'(cnt_b),   32'(cnt));
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        btn_a = 4'b0; btn_b = 4'b0;
        halt_a = 1'b0; halt_b = 1'b0;
        tick(2);

        // Power-on: 4 edges in RESET, then STOPPED.
        chk_a("por_hold", 3'd0, 1'b1, 1'b0, 16'd0);
        rst_a = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk_a("por_edge", 3'd0, 1'b1, 1'b0, 16'd0);
        end
        tick(1);
        chk_a("por_done", 3'd1, 1'b0, 1'b1, 16'd0);

        // Step held for 20 cycles: one enabled cycle after edge 7, no repeat.
        btn_a = 4'b0100;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("step_wait.en", 32'(en_a), 32'd0);
        end
        tick(1);
        chk_a("step_on", 3'd3, 1'b1, 1'b1, 16'd0);
        tick(1);
        chk_a("step_off", 3'd1, 1'b0, 1'b1, 16'd1);
        for (int i = 9; i <= 20; i++) begin
            tick(1);
            chk("step_hold.en", 32'(en_a), 32'd0);
        end
        chk_a("step_end", 3'd1, 1'b0, 1'b1, 16'd1);
        btn_a = 4'b0;
        tick(10);

        // 3-cycle RUN glitch is rejected.
        btn_a = 4'b0001;
        tick(3);
        btn_a = 4'b0;
        tick(10);
        chk_a("glitch", 3'd1, 1'b0, 1'b1, 16'd1);

        // RUN press, then simultaneous RUN+STOP while running -> STOPPED.
        btn_a = 4'b0001;
        tick(7);
        chk_a("run_on", 3'd2, 1'b1, 1'b1, 16'd1);
        btn_a = 4'b0;
        tick(10);
        chk_a("run_cont", 3'd2, 1'b1, 1'b1, 16'd11);
        btn_a = 4'b0011;
        tick(7);
        chk_a("run_stop", 3'd1, 1'b0, 1'b1, 16'd18);
        btn_a = 4'b0;
        tick(10);

        // RESET press from STOPPED clears count, 4 cycles in reset, back to STOPPED.
        btn_a = 4'b1000;
        tick(7);
        chk_a("rst_press", 3'd0, 1'b1, 1'b0, 16'd0);
        btn_a = 4'b0;
        tick(3);
        chk_a("rst_last", 3'd0, 1'b1, 1'b0, 16'd0);
        tick(1);
        chk_a("rst_exit", 3'd1, 1'b0, 1'b1, 16'd0);
        tick(10);

        // Run 10 cycles then HALT.
        btn_a = 4'b0001;
        tick(7);
        chk_a("run2_on", 3'd2, 1'b1, 1'b1, 16'd0);
        btn_a = 4'b0;
        tick(9);
        chk("run2_cnt9", 32'(cnt_a), 32'd9);
        halt_a = 1'b1;
        tick(1);
        chk_a("halt", 3'd4, 1'b0, 1'b1, 16'd10);
        halt_a = 1'b0;
        tick(2);
        chk_a("halt_hold", 3'd4, 1'b0, 1'b1, 16'd10);
        btn_a = 4'b0001;
        tick(10);
        btn_a = 4'b0;
        tick(10);
        chk_a("halt_run", 3'd4, 1'b0, 1'b1, 16'd10);
        btn_a = 4'b0100;
        tick(10);
        btn_a = 4'b0;
        tick(10);
        chk_a("halt_step", 3'd4, 1'b0, 1'b1, 16'd10);

        // RESET press out of HALTED, then RESET press mid-run.
        btn_a = 4'b1000;
        tick(7);
        chk_a("halt_rst", 3'd0, 1'b1, 1'b0, 16'd0);
        btn_a = 4'b0;
        tick(4);
        chk_a("halt_rst_exit", 3'd1, 1'b0, 1'b1, 16'd0);
        tick(6);
        btn_a = 4'b0001;
        tick(7);
        btn_a = 4'b0;
        tick(10);
        chk_a("mid_run", 3'd2, 1'b1, 1'b1, 16'd10);
        btn_a = 4'b1000;
        tick(6);
        for (int i = 7; i <= 10; i++) begin
            tick(1);
            chk_a("mid_rst", 3'd0, 1'b1, 1'b0, 16'd0);
        end
        tick(1);
        chk_a("mid_rst_exit", 3'd1, 1'b0, 1'b1, 16'd0);
        btn_a = 4'b0;

        // AUTORUN instance: power-on into RUNNING, counter wrap, reset press mid-run.
        tick(1);
        rst_b = 1'b0;
        tick(3);
        chk_b("b_por", 3'd0, 1'b1, 1'b0, 16'd0);
        tick(1);
        chk_b("b_autorun", 3'd2, 1'b1, 1'b1, 16'd0);
        tick(65537);
        chk_b("b_wrap", 3'd2, 1'b1, 1'b1, 16'd1);
        btn_b = 4'b1000;
        tick(6);
        for (int i = 7; i <= 10; i++) begin
            tick(1);
            chk_b("b_rst", 3'd0, 1'b1, 1'b0, 16'd0);
        end
        tick(1);
        chk_b("b_rst_exit", 3'd2, 1'b1, 1'b1, 16'd0);
        btn_b = 4'b0;
        tick(3);
        chk_b("b_rerun", 3'd2, 1'b1, 1'b1, 16'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
